// File: rtl/morse_key_encoder_if.sv
`default_nettype none
// ============================================================================
// Module      : morse_key_encoder_if
// Description : Key-in / symbol-out bundle of the Morse key encoder.
//               key_in      raw key level (1 = pressed)
//               sym_out     symbol pulse 00 none / 01 dot / 10 dash / 11 end
//               key_level   debounced key level
//               letter_open 1 while the current letter has at least one symbol
//               master = key source / symbol consumer, slave = the encoder.
// Revision    : 1.0  initial release
// ============================================================================
interface morse_key_encoder_if;
    logic       key_in;
    logic [1:0] sym_out;
    logic       key_level;
    logic       letter_open;

    modport master (
        output key_in,
        input  sym_out,
        input  key_level,
        input  letter_open
    );

    modport slave (
        input  key_in,
        output sym_out,
        output key_level,
        output letter_open
    );
endinterface
`default_nettype wire

// File: rtl/morse_key_encoder.sv
`default_nettype none
// ============================================================================
// Module      : morse_key_encoder
// Description : Synchronises and debounces a raw telegraph key, times each
//               press and release gap, and emits single-cycle Morse symbols
//               (01 dot, 10 dash, 11 end-of-letter) for the letter decoder.
// Ports       : clk    system clock
//               reset  asynchronous active-high reset
//               bus    morse_key_encoder_if.slave (key_in in; sym_out,
//                      key_level, letter_open out)
// Revision    : 1.0  initial release
// ============================================================================
module morse_key_encoder #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_CYC   = 16,
    parameter int DOT_MAX_CYC    = 200,
    parameter int LETTER_GAP_CYC = 600,
    parameter int MAX_SYMS       = 4,
    parameter int CNT_W          = 16
) (
    input  wire logic            clk,
    input  wire logic            reset,
    morse_key_encoder_if.slave   bus
);

    localparam int DB_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam int SC_W = $clog2(MAX_SYMS + 1);

    localparam logic [DB_W-1:0]  C_DB_LAST     = DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] C_DOT_MAX     = CNT_W'(DOT_MAX_CYC);
    localparam logic [CNT_W-1:0] C_GAP_LAST    = CNT_W'(LETTER_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_PRESS_FIRST = CNT_W'(1);
    localparam logic [SC_W-1:0]  C_SYMS_LAST   = SC_W'(MAX_SYMS - 1);

    localparam logic [1:0] C_SYM_NONE = 2'b00;
    localparam logic [1:0] C_SYM_DOT  = 2'b01;
    localparam logic [1:0] C_SYM_DASH = 2'b10;
    localparam logic [1:0] C_SYM_EOL  = 2'b11;

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_PRESS = 2'd1;
    localparam logic [1:0] C_ST_GAP   = 2'd2;
    localparam logic [1:0] C_ST_FORCE = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
    logic                   key_level_q, key_level_d;
    logic [1:0]             state_q, state_d;
    logic [CNT_W-1:0]       press_cnt_q, press_cnt_d;
    logic [CNT_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic [SC_W-1:0]        sym_cnt_q, sym_cnt_d;
    logic                   letter_open_q, letter_open_d;
    logic [1:0]             sym_q, sym_d;
    logic                   w_key_sync;

    // ------------------------------------------------------------------
    // Synchroniser and debouncer
    // ------------------------------------------------------------------
    assign w_key_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], bus.key_in};
        db_cnt_d    = '0;
        key_level_d = key_level_q;
        // Count consecutive disagreeing samples; any agreeing sample drops
        // the count back to zero through the default above.
        if (w_key_sync != key_level_q) begin
            if (db_cnt_q == C_DB_LAST) begin
                key_level_d = w_key_sync;
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Symbol timing FSM
    // ------------------------------------------------------------------
    // press_cnt is loaded with 1 on entry to PRESS because the cycle that
    // detected the rising level is already the first cycle of the press;
    // at the falling edge press_cnt then equals the press length, so a
    // press of exactly DOT_MAX_CYC cycles reads as a dash.
    always_comb begin
        state_d       = state_q;
        press_cnt_d   = press_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        sym_cnt_d     = sym_cnt_q;
        letter_open_d = letter_open_q;
        sym_d         = C_SYM_NONE;

        case (state_q)
            C_ST_IDLE: begin
                if (key_level_q) begin
                    state_d     = C_ST_PRESS;
                    press_cnt_d = C_PRESS_FIRST;
                end
            end

            C_ST_PRESS: begin
                if (key_level_q) begin
                    if (press_cnt_q < C_DOT_MAX) begin
                        press_cnt_d = press_cnt_q + 1'b1;
                    end
                end else begin
                    sym_d         = (press_cnt_q < C_DOT_MAX) ? C_SYM_DOT : C_SYM_DASH;
                    sym_cnt_d     = sym_cnt_q + 1'b1;
                    letter_open_d = 1'b1;
                    gap_cnt_d     = '0;
                    state_d       = (sym_cnt_q == C_SYMS_LAST) ? C_ST_FORCE : C_ST_GAP;
                end
            end

            C_ST_GAP: begin
                // Expiry is tested first so a rise on the expiry cycle still
                // closes the letter and then starts the next press.
                if (gap_cnt_q == C_GAP_LAST) begin
                    sym_d         = C_SYM_EOL;
                    sym_cnt_d     = '0;
                    letter_open_d = 1'b0;
                    if (key_level_q) begin
                        state_d     = C_ST_PRESS;
                        press_cnt_d = C_PRESS_FIRST;
                    end else begin
                        state_d = C_ST_IDLE;
                    end
                end else if (key_level_q) begin
                    gap_cnt_d   = '0;
                    state_d     = C_ST_PRESS;
                    press_cnt_d = C_PRESS_FIRST;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end

            C_ST_FORCE: begin
                sym_d         = C_SYM_EOL;
                sym_cnt_d     = '0;
                letter_open_d = 1'b0;
                if (key_level_q) begin
                    state_d     = C_ST_PRESS;
                    press_cnt_d = C_PRESS_FIRST;
                end else begin
                    state_d = C_ST_IDLE;
                end
            end

            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= '0;
            db_cnt_q      <= '0;
            key_level_q   <= 1'b0;
            state_q       <= C_ST_IDLE;
            press_cnt_q   <= '0;
            gap_cnt_q     <= '0;
            sym_cnt_q     <= '0;
            letter_open_q <= 1'b0;
            sym_q         <= C_SYM_NONE;
        end else begin
            sync_q        <= sync_d;
            db_cnt_q      <= db_cnt_d;
            key_level_q   <= key_level_d;
            state_q       <= state_d;
            press_cnt_q   <= press_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            sym_cnt_q     <= sym_cnt_d;
            letter_open_q <= letter_open_d;
            sym_q         <= sym_d;
        end
    end

    assign bus.sym_out     = sym_q;
    assign bus.key_level   = key_level_q;
    assign bus.letter_open = letter_open_q;

endmodule
`default_nettype wire
